// File: rtl/line_fetcher.sv
// Read-side fill engine: queues line requests, fetches each 64-byte line as one
// AXI4 INCR burst and returns the assembled line with the original addr/id/offset.
module line_fetcher #(
  parameter int unsigned C_M_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 128,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 40,
  parameter int unsigned C_BRAM_DATA_WIDTH  = 512,
  parameter int unsigned BEATS              = 4,
  parameter int unsigned CHANNEL_ADDR_WIDTH = 34,
  parameter int unsigned QUEUE_LENGTH       = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [CHANNEL_ADDR_WIDTH-1:0] request_notification_addr,
  input  logic [C_M_AXI_ID_WIDTH-1:0]   request_notification_id,
  input  logic [$clog2(BEATS)-1:0]      request_notification_offset,
  input  logic                          request_notification_valid,
  output logic                          monitor_bypass_ready,
  output logic [CHANNEL_ADDR_WIDTH-1:0] availability_notification_addr,
  output logic [C_M_AXI_ID_WIDTH-1:0]   availability_notification_id,
  output logic [$clog2(BEATS)-1:0]      availability_notification_offset,
  output logic [C_BRAM_DATA_WIDTH-1:0]  availability_notification_data,
  output logic                          availability_notification_valid,
  output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic [2:0]                    fetch_error
);

  localparam int unsigned OFF_W = $clog2(BEATS);
  localparam int unsigned PTR_W = (QUEUE_LENGTH > 1) ? $clog2(QUEUE_LENGTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_LENGTH + 1);
  localparam int unsigned W     = C_M_AXI_DATA_WIDTH;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_AR     = 2'd1;
  localparam logic [1:0] S_RDATA  = 2'd2;
  localparam logic [1:0] S_NOTIFY = 2'd3;

  logic [1:0] state, state_next;

  logic [CHANNEL_ADDR_WIDTH-1:0] q_addr [QUEUE_LENGTH];
  logic [C_M_AXI_ID_WIDTH-1:0]   q_id   [QUEUE_LENGTH];
  logic [OFF_W-1:0]              q_off  [QUEUE_LENGTH];
  logic [PTR_W-1:0]              wr_ptr, rd_ptr;
  logic [CNT_W-1:0]              count, count_next;

  logic [OFF_W-1:0]              beat_cnt;
  logic [C_BRAM_DATA_WIDTH-1:0]  line, line_next;

  logic full, empty, push, pop, drop;
  logic beat_ok, last_beat;
  logic unused_rid;

  assign unused_rid = ^M_AXI_RID;

  assign full      = (count == CNT_W'(QUEUE_LENGTH));
  assign empty     = (count == '0);
  assign pop       = (state == S_NOTIFY);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept then.
  assign push      = request_notification_valid && (!full || pop);
  assign drop      = request_notification_valid && full && !pop;
  assign beat_ok   = (state == S_RDATA) && M_AXI_RVALID && M_AXI_RREADY;
  assign last_beat = (beat_cnt == OFF_W'(BEATS - 1));

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (!push && pop) count_next = count - CNT_W'(1);
  end

  // Beat k lands in the k-th most significant slice of the line.
  always_comb begin
    line_next = line;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (beat_ok && (beat_cnt == OFF_W'(k)))
        line_next[(BEATS-1-k)*W +: W] = M_AXI_RDATA;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (!empty) state_next = S_AR;
      S_AR:     if (M_AXI_ARVALID && M_AXI_ARREADY) state_next = S_RDATA;
      S_RDATA:  if (beat_ok && last_beat) state_next = S_NOTIFY;
      S_NOTIFY: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_addr[wr_ptr] <= request_notification_addr;
      q_id[wr_ptr]   <= request_notification_id;
      q_off[wr_ptr]  <= request_notification_offset;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                            <= S_IDLE;
      wr_ptr                           <= '0;
      rd_ptr                           <= '0;
      count                            <= '0;
      monitor_bypass_ready             <= 1'b0;
      beat_cnt                         <= '0;
      line                             <= '0;
      M_AXI_ARVALID                    <= 1'b0;
      M_AXI_ARID                       <= '0;
      M_AXI_ARADDR                     <= '0;
      M_AXI_ARLEN                      <= '0;
      M_AXI_ARSIZE                     <= '0;
      M_AXI_ARBURST                    <= '0;
      M_AXI_RREADY                     <= 1'b0;
      availability_notification_valid  <= 1'b0;
      availability_notification_addr   <= '0;
      availability_notification_id     <= '0;
      availability_notification_offset <= '0;
      availability_notification_data   <= '0;
      fetch_error                      <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (push) wr_ptr <= (wr_ptr == PTR_W'(QUEUE_LENGTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(QUEUE_LENGTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      // Two free slots cover the push already in flight from the front-end.
      monitor_bypass_ready <= ((CNT_W'(QUEUE_LENGTH) - count_next) >= CNT_W'(2));

      M_AXI_ARVALID <= (state_next == S_AR);
      if (state_next == S_AR && state != S_AR) begin
        M_AXI_ARID    <= q_id[rd_ptr];
        M_AXI_ARADDR  <= C_M_AXI_ADDR_WIDTH'({q_addr[rd_ptr], 6'b0});
        M_AXI_ARLEN   <= 8'(BEATS - 1);
        M_AXI_ARSIZE  <= 3'($clog2(W / 8));
        M_AXI_ARBURST <= 2'b01;
      end

      M_AXI_RREADY <= (state_next == S_RDATA);
      if (beat_ok) beat_cnt <= beat_cnt + OFF_W'(1);
      line <= line_next;

      availability_notification_valid <= (state_next == S_NOTIFY);
      if (state_next == S_NOTIFY && state != S_NOTIFY) begin
        availability_notification_data   <= line_next;
        availability_notification_addr   <= q_addr[rd_ptr];
        availability_notification_id     <= q_id[rd_ptr];
        availability_notification_offset <= q_off[rd_ptr];
      end

      if (beat_ok && M_AXI_RRESP != 2'b00)  fetch_error[0] <= 1'b1;
      if (beat_ok && M_AXI_RLAST != last_beat) fetch_error[1] <= 1'b1;
      if (drop)                             fetch_error[2] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_line_fetcher.sv
// Directed bench for line_fetcher with an AXI read responder and a scoreboard
// of expected availability notifications.
module tb_line_fetcher;

  logic         clock = 1'b0;
  logic         reset;
  logic [33:0]  req_addr;
  logic [0:0]   req_id;
  logic [1:0]   req_off;
  logic         req_valid;
  logic         ready;
  logic [33:0]  av_addr;
  logic [0:0]   av_id;
  logic [1:0]   av_off;
  logic [511:0] av_data;
  logic         av_valid;
  logic [0:0]   arid;
  logic [39:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [0:0]   rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [2:0]   ferr;

  typedef struct {
    logic [33:0]  addr;
    logic [0:0]   id;
    logic [1:0]   off;
    logic [511:0] line;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  line_fetcher dut (
    .clock(clock), .reset(reset),
    .request_notification_addr(req_addr), .request_notification_id(req_id),
    .request_notification_offset(req_off), .request_notification_valid(req_valid),
    .monitor_bypass_ready(ready),
    .availability_notification_addr(av_addr), .availability_notification_id(av_id),
    .availability_notification_offset(av_off), .availability_notification_data(av_data),
    .availability_notification_valid(av_valid),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .fetch_error(ferr)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [511:0] gen_line(input logic [33:0] a);
    logic [511:0] l;
    for (int k = 0; k < 4; k++)
      l[(3-k)*128 +: 128] = {32'hC0DE0000 | 32'(k), 32'(a), ~32'(a), 32'(a) + 32'(k * 7)};
    return l;
  endfunction

  task automatic push_req(input logic [33:0] a, input logic [0:0] id, input logic [1:0] off,
                          input logic [511:0] l, input bit dropped);
    exp_t e;
    req_addr = a; req_id = id; req_off = off; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    if (!dropped) begin
      e.addr = a; e.id = id; e.off = off; e.line = l;
      sb.push_back(e);
    end
  endtask

  // Serves the head request; gap inserts idle cycles before beats 1..3,
  // resp_beat / bad_last_beat select the beat carrying SLVERR / a wrong RLAST.
  task automatic serve(input bit gap, input int resp_beat, input int bad_last_beat);
    exp_t e;
    int n;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL serve: scoreboard empty observed 0 expected >0");
      return;
    end
    e = sb[0];
    n = 0;
    while (!arvalid && n < 100) begin step(); n++; end
    check("arvalid", 512'(arvalid), 512'(1));
    check("araddr", 512'(araddr), 512'({e.addr, 6'b0}));
    check("arid", 512'(arid), 512'(e.id));
    check("arlen", 512'(arlen), 512'(3));
    check("arsize", 512'(arsize), 512'(4));
    check("arburst", 512'(arburst), 512'(1));
    step();
    check("arvalid_drop", 512'(arvalid), 512'(0));
    for (int k = 0; k < 4; k++) begin
      if (gap && k > 0) begin
        rvalid = 1'b0;
        step();
      end
      rvalid = 1'b1;
      rdata  = e.line[(3-k)*128 +: 128];
      rresp  = (k == resp_beat) ? 2'b10 : 2'b00;
      rlast  = (k == 3) ^ (k == bad_last_beat);
      check("rready", 512'(rready), 512'(1));
      step();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    e = sb.pop_front();
    check("av_valid", 512'(av_valid), 512'(1));
    check("av_addr", 512'(av_addr), 512'(e.addr));
    check("av_id", 512'(av_id), 512'(e.id));
    check("av_off", 512'(av_off), 512'(e.off));
    check("av_data", av_data, e.line);
    step();
    check("av_valid_pulse", 512'(av_valid), 512'(0));
    check("av_data_hold", av_data, e.line);
  endtask

  initial begin
    logic [511:0] l1;
    int n;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_id = '0; req_off = '0;
    arready = 1'b1; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    repeat (3) step();
    check("rst_arvalid", 512'(arvalid), 512'(0));
    check("rst_araddr", 512'(araddr), 512'(0));
    check("rst_rready", 512'(rready), 512'(0));
    check("rst_av_valid", 512'(av_valid), 512'(0));
    check("rst_av_data", av_data, 512'(0));
    check("rst_ready", 512'(ready), 512'(0));
    check("rst_ferr", 512'(ferr), 512'(0));
    reset = 1'b0;
    step();
    check("ready_rise", 512'(ready), 512'(1));

    // Single request with explicit beat values and AR latency
    l1 = {{8{16'hAAAA}}, {8{16'hBBBB}}, {8{16'hCCCC}}, {8{16'hDDDD}}};
    push_req(34'h3, 1'b1, 2'd2, l1, 1'b0);
    check("t1_ar_not_yet", 512'(arvalid), 512'(0));
    step();
    check("t1_ar_latency", 512'(arvalid), 512'(1));
    check("t1_araddr", 512'(araddr), 512'(40'hC0));
    serve(1'b0, -1, -1);
    check("t1_ferr", 512'(ferr), 512'(0));

    // RVALID gaps with SLVERR on the third beat
    push_req(34'h12345, 1'b0, 2'd1, gen_line(34'h12345), 1'b0);
    serve(1'b1, 2, -1);
    check("t3_ferr", 512'(ferr), 512'(3'b001));

    // Early RLAST on the second beat
    push_req(34'h2AAAAAAAA, 1'b1, 2'd3, gen_line(34'h2AAAAAAAA), 1'b0);
    serve(1'b0, -1, 1);
    check("t4_ferr", 512'(ferr), 512'(3'b011));

    // Reset during the second beat abandons the burst
    push_req(34'h55, 1'b0, 2'd0, gen_line(34'h55), 1'b0);
    n = 0;
    while (!arvalid && n < 100) begin step(); n++; end
    step();
    rvalid = 1'b1; rdata = sb[0].line[511:384]; rlast = 1'b0;
    step();
    rdata = sb[0].line[383:256]; reset = 1'b1;
    step();
    reset = 1'b0; rvalid = 1'b0;
    sb.delete();
    check("mr_arvalid", 512'(arvalid), 512'(0));
    check("mr_araddr", 512'(araddr), 512'(0));
    check("mr_rready", 512'(rready), 512'(0));
    check("mr_av_valid", 512'(av_valid), 512'(0));
    check("mr_av_data", av_data, 512'(0));
    check("mr_av_addr", 512'(av_addr), 512'(0));
    check("mr_ferr", 512'(ferr), 512'(0));
    check("mr_ready", 512'(ready), 512'(0));
    step();
    check("mr_no_notify", 512'(av_valid), 512'(0));
    check("mr_ready_back", 512'(ready), 512'(1));
    repeat (3) step();
    check("mr_fifo_empty", 512'(arvalid), 512'(0));
    push_req(34'h77, 1'b1, 2'd1, gen_line(34'h77), 1'b0);
    serve(1'b0, -1, -1);
    check("mr_ferr_after", 512'(ferr), 512'(0));

    // Fill with ARREADY low, overflow push, then drain in order
    arready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      logic [33:0] a;
      a = 34'h100 + 34'(i * 3);
      push_req(a, 1'(i), 2'(i), gen_line(a), 1'b0);
      check("fill_ready", 512'(ready), 512'((8 - i) >= 2));
      step();
    end
    check("fill_ferr", 512'(ferr), 512'(0));
    check("fill_ar_held", 512'(araddr), 512'({34'h103, 6'b0}));
    push_req(34'h200, 1'b0, 2'd0, gen_line(34'h200), 1'b0);
    check("full_ready", 512'(ready), 512'(0));
    check("full_ferr", 512'(ferr), 512'(0));
    push_req(34'h3FF, 1'b1, 2'd3, gen_line(34'h3FF), 1'b1);
    check("ovf_ferr", 512'(ferr), 512'(3'b100));
    arready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      serve(1'b0, -1, -1);
      if (i < 7) begin
        step();
        check("next_ar_n3", 512'(arvalid), 512'(1));
      end
    end
    check("drain_empty", 512'(sb.size()), 512'(0));
    repeat (3) step();
    check("drain_idle", 512'(arvalid), 512'(0));
    check("drain_ferr", 512'(ferr), 512'(3'b100));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
